// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
//
// Shared definitions for the multiplexed seven-segment display driver.
//   - SEG_A..SEG_G, SEG_DP : bit positions of each segment in the 8-bit
//                            segment word (bit0 = a ... bit6 = g, bit7 = dp).
//   - FONT                 : active-high hex font, one 7-bit pattern per nibble.
//   - hex_to_seg()         : nibble -> 7-bit segment pattern lookup.
// -----------------------------------------------------------------------------
package seven_seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Hex glyphs 0-9, A, b, C, d, E, F (lower-case b/d keep them distinct
    // from 8/0 on a seven-segment cell).
    localparam logic [6:0] FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return FONT[nibble];
    endfunction

endpackage

// File: rtl/seven_seg_font.sv
// -----------------------------------------------------------------------------
// seven_seg_font
//
// Combinational hex-to-segment decoder. A single instance sits on the nibble
// selected for the digit currently being scanned.
//
// Ports
//   nibble_i : 4-bit hex value to display
//   seg_o    : 7-bit active-high pattern, bit0 = a ... bit6 = g
// -----------------------------------------------------------------------------
module seven_seg_font
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = hex_to_seg(nibble_i);
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
//
// Self-scanning multiplexed seven-segment driver. Each digit owns a slot of
// 16 PWM sub-slots of SUB_DIV clocks; a frame is N_DIGITS slots. Host data is
// captured into shadow registers only at frame boundaries so a frame never
// shows a mix of old and new values.
//
// Ports
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   data       : 4*N_DIGITS hex nibbles, nibble i -> digit i (digit 0 rightmost)
//   load       : request to latch data / dp_mask / blink_mask at next boundary
//   dp_mask    : decimal point enable per digit
//   blink_mask : blink enable per digit
//   lz_blank   : blank leading zeros (live)
//   brightness : lit for brightness+1 of 16 sub-slots (live)
//   digit      : registered one-hot digit select (polarity per DIGIT_ACTIVE_LOW)
//   seg        : registered segments, bit7 = dp (polarity per SEG_ACTIVE_LOW)
//   frame_tick : one-cycle pulse alongside the first output of each new frame
// -----------------------------------------------------------------------------
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS         = 8,
    parameter int SUB_DIV          = 6250,
    parameter int BLINK_FRAMES     = 32,
    parameter bit SEG_ACTIVE_LOW   = 1'b0,
    parameter bit DIGIT_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] data,
    input  logic                  load,
    input  logic [N_DIGITS-1:0]   dp_mask,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic                  lz_blank,
    input  logic [3:0]            brightness,
    output logic [N_DIGITS-1:0]   digit,
    output logic [7:0]            seg,
    output logic                  frame_tick
);

    localparam int SUB_W = (SUB_DIV > 1)      ? $clog2(SUB_DIV)      : 1;
    localparam int IDX_W = (N_DIGITS > 1)     ? $clog2(N_DIGITS)     : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    localparam logic [N_DIGITS-1:0] DIGIT_OFF = {N_DIGITS{DIGIT_ACTIVE_LOW}};
    localparam logic [7:0]          SEG_OFF   = {8{SEG_ACTIVE_LOW}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SUB_W-1:0]      sub_cnt_q,     sub_cnt_d;
    logic [3:0]            pwm_idx_q,     pwm_idx_d;
    logic [IDX_W-1:0]      idx_q,         idx_d;
    logic                  pending_q,     pending_d;
    logic [4*N_DIGITS-1:0] sh_data_q,     sh_data_d;
    logic [N_DIGITS-1:0]   sh_dp_q,       sh_dp_d;
    logic [N_DIGITS-1:0]   sh_blink_q,    sh_blink_d;
    logic [BLK_W-1:0]      blink_cnt_q,   blink_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic                  boundary_q;
    logic [N_DIGITS-1:0]   digit_q,       digit_d;
    logic [7:0]            seg_q,         seg_d;
    logic                  frame_tick_q;

    logic                  sub_wrap;
    logic                  pwm_wrap;
    logic                  idx_last;
    logic                  boundary;

    // ------------------------------------------------------------------
    // Scan counters: sub_cnt -> pwm_idx -> idx
    // ------------------------------------------------------------------
    always_comb begin
        sub_wrap  = (sub_cnt_q == SUB_LAST);
        pwm_wrap  = sub_wrap && (pwm_idx_q == 4'hF);
        idx_last  = (idx_q == IDX_LAST);
        boundary  = pwm_wrap && idx_last;

        sub_cnt_d = sub_wrap ? '0 : sub_cnt_q + 1'b1;
        pwm_idx_d = sub_wrap ? pwm_idx_q + 4'd1 : pwm_idx_q;
        idx_d     = idx_q;
        if (pwm_wrap) begin
            idx_d = idx_last ? '0 : idx_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Shadow capture and blink phase, both advanced only at the frame
    // boundary. A load arriving in the boundary cycle itself is taken
    // directly, without waiting for pending to be set.
    // ------------------------------------------------------------------
    always_comb begin
        pending_d     = pending_q | load;
        sh_data_d     = sh_data_q;
        sh_dp_d       = sh_dp_q;
        sh_blink_d    = sh_blink_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;

        if (boundary) begin
            if (pending_q || load) begin
                sh_data_d  = data;
                sh_dp_d    = dp_mask;
                sh_blink_d = blink_mask;
                pending_d  = 1'b0;
            end
            if (blink_cnt_q == BLK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-digit selection for the digit currently being scanned.
    // zero_from[i] is set when nibbles i..N_DIGITS-1 are all zero, i.e.
    // digit i is a leading zero.
    // ------------------------------------------------------------------
    logic [N_DIGITS-1:0] zero_from;
    logic                zero_run;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blink;
    logic                cur_zero;
    logic [N_DIGITS-1:0] cur_onehot;

    always_comb begin
        zero_from  = '0;
        zero_run   = 1'b1;
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_blink  = 1'b0;
        cur_zero   = 1'b0;
        cur_onehot = '0;

        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run & (sh_data_q[4*i +: 4] == 4'h0);
            zero_from[i] = zero_run;
        end

        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib       = sh_data_q[4*i +: 4];
                cur_dp        = sh_dp_q[i];
                cur_blink     = sh_blink_q[i];
                cur_zero      = zero_from[i];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    logic [6:0] font_seg;

    seven_seg_font u_font (
        .nibble_i (cur_nib),
        .seg_o    (font_seg)
    );

    // ------------------------------------------------------------------
    // Output word. Blanking (LZ, blink, PWM) kills both the digit select
    // and every segment including dp; polarity is applied last so the
    // unlit level matches the reset level.
    // ------------------------------------------------------------------
    logic lz_off;
    logic blink_off;
    logic lit;

    always_comb begin
        lz_off    = lz_blank && (idx_q != '0) && cur_zero;
        blink_off = blink_phase_q && cur_blink;
        lit       = !lz_off && !blink_off && (pwm_idx_q <= brightness);

        digit_d = '0;
        seg_d   = '0;
        if (lit) begin
            digit_d             = cur_onehot;
            seg_d[SEG_G:SEG_A]  = font_seg;
            seg_d[SEG_DP]       = cur_dp;
        end
        digit_d = digit_d ^ DIGIT_OFF;
        seg_d   = seg_d ^ SEG_OFF;
    end

    // ------------------------------------------------------------------
    // Registers. frame_tick is delayed twice from the boundary so it
    // coincides with the registered output of idx 0 / sub-slot 0 built
    // from the freshly captured shadow.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_cnt_q     <= '0;
            pwm_idx_q     <= '0;
            idx_q         <= '0;
            pending_q     <= 1'b0;
            sh_data_q     <= '0;
            sh_dp_q       <= '0;
            sh_blink_q    <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            boundary_q    <= 1'b0;
            digit_q       <= DIGIT_OFF;
            seg_q         <= SEG_OFF;
            frame_tick_q  <= 1'b0;
        end else begin
            sub_cnt_q     <= sub_cnt_d;
            pwm_idx_q     <= pwm_idx_d;
            idx_q         <= idx_d;
            pending_q     <= pending_d;
            sh_data_q     <= sh_data_d;
            sh_dp_q       <= sh_dp_d;
            sh_blink_q    <= sh_blink_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            boundary_q    <= boundary;
            digit_q       <= digit_d;
            seg_q         <= seg_d;
            frame_tick_q  <= boundary_q;
        end
    end

    assign digit      = digit_q;
    assign seg        = seg_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scanner
//
// Directed bench for seven_seg_scanner with N_DIGITS=4, SUB_DIV=2,
// BLINK_FRAMES=2: a slot is 32 clocks and a frame is 128 clocks. Outputs are
// sampled on the falling edge; sample j of a frame is the registered output
// for counter state j of that frame (slot j/32, PWM sub-slot (j%32)/2).
// -----------------------------------------------------------------------------
module tb_seven_seg_scanner;

    logic        clk;
    logic        rst_n;
    logic [15:0] data;
    logic        load;
    logic [3:0]  dp_mask;
    logic [3:0]  blink_mask;
    logic        lz_blank;
    logic [3:0]  brightness;
    logic [3:0]  digit;
    logic [7:0]  seg;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    seven_seg_scanner #(
        .N_DIGITS         (4),
        .SUB_DIV          (2),
        .BLINK_FRAMES     (2),
        .SEG_ACTIVE_LOW   (1'b0),
        .DIGIT_ACTIVE_LOW (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .load       (load),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .lz_blank   (lz_blank),
        .brightness (brightness),
        .digit      (digit),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset held, then released on a falling edge.
    task automatic test_reset();
        rst_n      = 1'b0;
        data       = 16'h0000;
        load       = 1'b0;
        dp_mask    = 4'b0000;
        blink_mask = 4'b0000;
        lz_blank   = 1'b0;
        brightness = 4'hF;
        repeat (3) @(negedge clk);
        checks++;
        if (digit !== 4'b0000) begin
            errors++;
            $display("FAIL reset_digit got %b want 0000", digit);
        end
        checks++;
        if (seg !== 8'h00) begin
            errors++;
            $display("FAIL reset_seg got %h want 00", seg);
        end
        checks++;
        if (frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_tick got %b want 0", frame_tick);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({digit, seg} !== 12'h000) begin
            errors++;
            $display("FAIL release_idle got digit=%b seg=%h want 0000/00", digit, seg);
        end
    endtask

    // Frame 0 after reset: "0000" at full brightness; load 12AF at j=40.
    task automatic test_power_on_scan();
        logic [3:0] ed;
        logic [7:0] es;
        logic       et;
        for (int j = 0; j < 128; j++) begin
            @(negedge clk);
            ed = 4'b0001 << (j / 32);
            es = 8'h3F;
            et = 1'b0;
            checks++;
            if ({digit, seg, frame_tick} !== {ed, es, et}) begin
                errors++;
                $display("FAIL scan j=%0d got digit=%b seg=%h tick=%b want digit=%b seg=%h tick=%b",
                         j, digit, seg, frame_tick, ed, es, et);
            end
            if (j == 40) begin
                data = 16'h12AF;
                load = 1'b1;
            end
            if (j == 41) load = 1'b0;
        end
    endtask

    // Frame 1: 12AF shown. A second load (3333) is overtaken by data that
    // changes without a load; the boundary value 0005 must win.
    task automatic test_load_update();
        logic [7:0] font_exp [4];
        logic [3:0] ed;
        logic [7:0] es;
        logic       et;
        font_exp = '{8'h71, 8'h77, 8'h5B, 8'h06};
        for (int j = 0; j < 128; j++) begin
            @(negedge clk);
            ed = 4'b0001 << (j / 32);
            es = font_exp[j / 32];
            et = (j == 0);
            checks++;
            if ({digit, seg, frame_tick} !== {ed, es, et}) begin
                errors++;
                $display("FAIL load j=%0d got digit=%b seg=%h tick=%b want digit=%b seg=%h tick=%b",
                         j, digit, seg, frame_tick, ed, es, et);
            end
            if (j == 10) begin
                data = 16'h3333;
                load = 1'b1;
            end
            if (j == 11)  load = 1'b0;
            if (j == 50)  data = 16'h0005;
            if (j == 100) lz_blank = 1'b1;
        end
    endtask

    // Frame 2: 0005 with leading-zero blanking.
    task automatic test_lz_blank();
        logic [3:0] ed;
        logic [7:0] es;
        logic       et;
        for (int j = 0; j < 128; j++) begin
            @(negedge clk);
            ed = (j < 32) ? 4'b0001 : 4'b0000;
            es = (j < 32) ? 8'h6D : 8'h00;
            et = (j == 0);
            checks++;
            if ({digit, seg, frame_tick} !== {ed, es, et}) begin
                errors++;
                $display("FAIL lz j=%0d got digit=%b seg=%h tick=%b want digit=%b seg=%h tick=%b",
                         j, digit, seg, frame_tick, ed, es, et);
            end
            if (j == 127) begin
                brightness = 4'h3;
                lz_blank   = 1'b0;
            end
        end
    endtask

    // Frame 3: brightness 3 -> 8 lit then 24 dark clocks per slot.
    task automatic test_brightness();
        logic [3:0] ed;
        logic [7:0] es;
        logic       et;
        for (int j = 0; j < 128; j++) begin
            @(negedge clk);
            if ((j % 32) < 8) begin
                ed = 4'b0001 << (j / 32);
                es = (j < 32) ? 8'h6D : 8'h3F;
            end else begin
                ed = 4'b0000;
                es = 8'h00;
            end
            et = (j == 0);
            checks++;
            if ({digit, seg, frame_tick} !== {ed, es, et}) begin
                errors++;
                $display("FAIL bright j=%0d got digit=%b seg=%h tick=%b want digit=%b seg=%h tick=%b",
                         j, digit, seg, frame_tick, ed, es, et);
            end
            if (j == 5) begin
                blink_mask = 4'b0001;
                dp_mask    = 4'b0010;
                load       = 1'b1;
            end
            if (j == 6)   load = 1'b0;
            if (j == 127) brightness = 4'hF;
        end
    endtask

    // Frames 4..7: digit 0 blinks (lit in 4,5, dark in 6,7); digit 1 has dp.
    task automatic test_blink_dp();
        logic [3:0] ed;
        logic [7:0] es;
        logic       et;
        for (int f = 0; f < 4; f++) begin
            for (int j = 0; j < 128; j++) begin
                @(negedge clk);
                case (j / 32)
                    0: begin
                        ed = (f >= 2) ? 4'b0000 : 4'b0001;
                        es = (f >= 2) ? 8'h00 : 8'h6D;
                    end
                    1:       begin ed = 4'b0010; es = 8'hBF; end
                    2:       begin ed = 4'b0100; es = 8'h3F; end
                    default: begin ed = 4'b1000; es = 8'h3F; end
                endcase
                et = (j == 0);
                checks++;
                if ({digit, seg, frame_tick} !== {ed, es, et}) begin
                    errors++;
                    $display("FAIL blink f=%0d j=%0d got digit=%b seg=%h tick=%b want digit=%b seg=%h tick=%b",
                             f, j, digit, seg, frame_tick, ed, es, et);
                end
            end
        end
    endtask

    // Frame 8: queue a load of 9999, then pulse reset mid-slot. The pending
    // load, the dp/blink shadows and the counters must all be gone.
    task automatic test_reset_mid();
        logic [3:0] ed;
        logic [7:0] es;
        logic       et;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            case (j / 32)
                0:       begin ed = 4'b0001; es = 8'h6D; end
                default: begin ed = 4'b0010; es = 8'hBF; end
            endcase
            et = (j == 0);
            checks++;
            if ({digit, seg, frame_tick} !== {ed, es, et}) begin
                errors++;
                $display("FAIL premid j=%0d got digit=%b seg=%h tick=%b want digit=%b seg=%h tick=%b",
                         j, digit, seg, frame_tick, ed, es, et);
            end
            if (j == 20) begin
                data = 16'h9999;
                load = 1'b1;
            end
            if (j == 21) load = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({digit, seg, frame_tick} !== 13'h0000) begin
            errors++;
            $display("FAIL async_rst got digit=%b seg=%h tick=%b want 0000/00/0",
                     digit, seg, frame_tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 256; j++) begin
            @(negedge clk);
            ed = 4'b0001 << ((j % 128) / 32);
            es = 8'h3F;
            et = (j == 128);
            checks++;
            if ({digit, seg, frame_tick} !== {ed, es, et}) begin
                errors++;
                $display("FAIL postrst j=%0d got digit=%b seg=%h tick=%b want digit=%b seg=%h tick=%b",
                         j, digit, seg, frame_tick, ed, es, et);
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_on_scan();
        test_load_update();
        test_lz_blank();
        test_brightness();
        test_blink_dp();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Parametrised, self-scanning multiplexed seven-segment display driver for the board's debug display. It sits between the processor's debug/MMIO data word and the FND pins. It owns the scan timing, tear-free data latching, leading-zero blanking, per-digit blink and decimal point, and 16-level brightness PWM. It replaces externally clocked, purely combinational digit selection.

## Interface
- N_DIGITS, 8, number of digits scanned (1..16)
- SUB_DIV, 6250, clock cycles per PWM sub-slot; one digit slot = 16·SUB_DIV cycles
- BLINK_FRAMES, 32, frames per blink half-period (≥1)
- SEG_ACTIVE_LOW, 0, invert `seg` at the output register
- DIGIT_ACTIVE_LOW, 0, invert `digit` at the output register
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- data  in  4·N_DIGITS  hex nibbles; nibble i drives digit i (digit 0 is rightmost)
- load  in  1  request to latch `data`, `dp_mask`, `blink_mask`
- dp_mask  in  N_DIGITS  decimal point on per digit
- blink_mask  in  N_DIGITS  blink enable per digit
- lz_blank  in  1  blank leading zeros (sampled live)
- brightness  in  4  duty level; lit for brightness+1 of 16 sub-slots
- digit  out  N_DIGITS  one-hot digit select (registered)
- seg  out  8  bit0..6 = a..g, bit7 = dp (registered)
- frame_tick  out  1  one-cycle pulse at each shadow update / frame start

## Operation
- Counters: `sub_cnt` counts 0..SUB_DIV−1. `pwm_idx` (4 b) increments when `sub_cnt` wraps. `idx` increments when `pwm_idx` wraps from 15, and wraps from N_DIGITS−1 to 0.
- Frame boundary: the cycle in which `idx`, `pwm_idx` and `sub_cnt` are all at maximum.
- Shadow registers `sh_data`, `sh_dp`, `sh_blink`:
  - `load` sets `pending`.
  - At a frame boundary with `pending` or `load` high, copy the inputs into the shadow and clear `pending`.
  - Several loads in one frame: the values present at the boundary win.
- Font, active-high: 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71.
- Leading-zero mask: digit i is blanked when `lz_blank`=1, i>0, and all nibbles i..N_DIGITS−1 of `sh_data` are 0. Digit 0 is never LZ-blanked.
- Blink: `blink_phase` toggles every BLINK_FRAMES frame boundaries. While `blink_phase`=1, digits with `sh_blink` set are blanked.
- Lit condition for current `idx`: not LZ-blanked, not blink-blanked, and `pwm_idx` ≤ `brightness`.
  - Lit: `digit` = one-hot(idx); `seg` = {sh_dp[idx], font(nibble idx)}.
  - Unlit: `digit` = 0 and `seg` = 0, before polarity inversion.
- The DP bit on an LZ-blanked digit is suppressed too.

## Timing
- Reset (async assert, sync release): all counters 0, `idx`=0, `pending`=0, `blink_phase`=0, shadows 0, `frame_tick`=0. Output registers hold the inactive level: `digit` = all-0 (all-1 if DIGIT_ACTIVE_LOW), `seg` = all-0 (all-1 if SEG_ACTIVE_LOW).
- Outputs lag the counter state by exactly 1 cycle. The first lit digit appears on the cycle after reset release (idx 0, showing shadow 0 → "0").
- `frame_tick` is high in the cycle after the boundary, aligned with the first output of idx 0. It pulses every frame regardless of `load`.
- `load` needs no handshake; a single-cycle pulse is sufficient.
- `brightness` and `lz_blank` are sampled every cycle. Changing them mid-slot takes effect on the next output cycle.
- Reset mid-frame discards `pending` and the shadows.
- N_DIGITS=1: `idx` stays 0 and every digit slot is a frame boundary.

## Structure
- Package `seven_seg_pkg`:
  - font constant array [16][7]
  - segment bit position localparams (SEG_A..SEG_G, SEG_DP)
  - function `hex_to_seg(nibble)`
- Sub-module `seven_seg_font`: combinational nibble → 7-bit pattern using the package function. It is instantiated once on the muxed nibble.
- Counters, shadow, blink and output logic live in `seven_seg_scanner`.

## Test plan
Bench parameters: N_DIGITS=4, SUB_DIV=2 (slot 32 cycles, frame 128 cycles), BLINK_FRAMES=2.
- Reset release with brightness=F → `digit` cycles 0001/0010/0100/1000, each for 32 cycles; `seg`=3F on every digit (lz_blank=0).
- load data=16'h12AF at cycle 40 → display unchanged until the boundary at cycle 127; from cycle 128 `seg` = 71, 77, 5B, 06 on digits 0..3; `frame_tick` pulses at 128.
- data=16'h0005, lz_blank=1 → digit 0 shows 6D; digits 1–3 have `digit`=0 and `seg`=0 in their slots.
- brightness=3 → each slot shows 8 lit cycles then 24 dark cycles (digit=0, seg=0).
- blink_mask=4'b0001, dp_mask=4'b0010 → digit 0 is dark in alternate 2-frame periods; digit 1's `seg` has bit7 set.
- rst_n pulsed low mid-slot for 1 cycle with load pending → outputs go inactive immediately; afterwards "0000" is shown and the pending load is lost.
